fsk_modulator_tx: RTL and testbench
===================================

FSK_MODULATOR_TX -- requirements
Module: fsk_modulator_tx

Interface
REQ-001 SHALL have parameter SYMBOL_LEN, default 100, samples per symbol (matches the demodulator frame of N+1).
REQ-002 SHALL have parameter SYNC_LEN, default 16, preamble length in cycles.
REQ-003 SHALL have parameter SYNC_LEVEL, default 1000, preamble sine amplitude.
REQ-004 SHALL have parameter AMPL, default 100000, tone peak amplitude.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, symbol FIFO entries (power of 2).
REQ-006 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port sym_in, input, 4, symbol 0-15 to transmit.
REQ-009 SHALL have port sym_in_valid, input, 1, sym_in valid.
REQ-010 SHALL have port sym_in_ready, output, 1, FIFO can accept.
REQ-011 SHALL have port dac_out_sin, output, signed 18, I sample (drives demodulator adc_in_sin).
REQ-012 SHALL have port dac_out_cos, output, signed 18, Q sample (drives adc_in_cos).
REQ-013 SHALL have port busy, output, 1, state not IDLE.
REQ-014 SHALL have port tx_symbol, output, 4, symbol currently on air.

Function
REQ-015 SHALL push sym_in into the FIFO on a rising clk edge where sym_in_valid and sym_in_ready are both 1; sym_in_ready = FIFO not full, combinational from FIFO count only.
REQ-016 SHALL ignore sym_in_valid while full; no overwrite, no drop counter.
REQ-017 SHALL implement states IDLE, SYNC, SYMBOL.
REQ-018 IDLE: outputs 0/0; FIFO non-empty at an edge -> SYNC (preamble built in) else stay.
REQ-019 SYNC: dac_out_sin = SYNC_LEVEL, dac_out_cos = 0 for exactly SYNC_LEN cycles, then SYMBOL with FIFO pop on the transition cycle.
REQ-020 SYMBOL: sample counter 0..SYMBOL_LEN-1; phase accumulator 32-bit, cleared to 0 at counter 0, incremented by PINC[k] each cycle, wraps modulo 2^32.
REQ-021 PINC[k] SHALL equal round((k+1)*2^32/100) (1 MHz..16 MHz at 100 MS/s); PINC[0] = 42949673.
REQ-022 Sample n SHALL be dac_out_sin = round(AMPL*sin(2*pi*p/1024)), dac_out_cos = round(AMPL*cos(2*pi*p/1024)), p = phase[31:22]; LUT of 1024 entries computed at elaboration.
REQ-023 Sample 0 of each symbol SHALL appear on the outputs exactly one cycle after the state/counter update (registered outputs); first SYMBOL sample: sin 0, cos AMPL.
REQ-024 At counter SYMBOL_LEN-1: FIFO non-empty -> pop next symbol, counter 0, phase 0, stay SYMBOL with no gap; FIFO empty -> IDLE.
REQ-025 Push and pop in the same cycle SHALL both occur; count unchanged.
REQ-026 tx_symbol SHALL update on each pop and hold otherwise.
REQ-027 Pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-028 reset SHALL asynchronously force IDLE, FIFO empty, counter 0, phase 0, dac_out_sin 0, dac_out_cos 0, busy 0, tx_symbol 0, sym_in_ready 1.
REQ-029 Reset mid-SYNC or mid-SYMBOL SHALL abort; queued symbols discarded; after release the next burst restarts with a full preamble.

Configuration
REQ-030 Macro FSK_MOD_SYNC_EN defined: preamble per REQ-019 at the start of every burst.
REQ-031 FSK_MOD_SYNC_EN undefined: SYNC state absent; IDLE with FIFO non-empty SHALL pop and enter SYMBOL directly.

Verification
REQ-032 Reset, push sym 0 -> busy next cycle; 16 cycles sin=1000/cos=0; then 100 samples starting sin 0, cos 100000; then IDLE, outputs 0.
REQ-033 Push 3, 7, 15 back-to-back -> one preamble, three 100-sample symbols, no gap, phase restarts at 0 each; tx_symbol 3,7,15.
REQ-034 Hold valid with 6 symbols while idle -> ready drops after 4 accepted; ready rises on the first pop; all 6 transmitted in order.
REQ-035 Assert reset at sample 50 of symbol 2 -> outputs 0 immediately, FIFO empty; new push yields fresh preamble.
REQ-036 Loop to fsk_demodulator, symbols 0..15 -> demodulator data_out equals each transmitted symbol.
REQ-037 Build without FSK_MOD_SYNC_EN, push 5 -> first tone sample one cycle after leaving IDLE, no preamble.

Source files
------------

// File: rtl/fsk_modulator_tx.sv
// rtl/fsk_modulator_tx.sv - 16-tone FSK transmitter: symbol FIFO, phase-accumulator tone generator, I/Q sine LUT.
// Define FSK_MOD_SYNC_EN to start every burst with a SYNC_LEN-cycle SYNC_LEVEL preamble.
module fsk_modulator_tx #(
  parameter int SYMBOL_LEN = 100,
  parameter int SYNC_LEN   = 16,
  parameter int SYNC_LEVEL = 1000,
  parameter int AMPL       = 100000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         sym_in,
  input  logic               sym_in_valid,
  output logic               sym_in_ready,
  output logic signed [17:0] dac_out_sin,
  output logic signed [17:0] dac_out_cos,
  output logic               busy,
  output logic [3:0]         tx_symbol
);
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_MAX = (SYMBOL_LEN > SYNC_LEN) ? SYMBOL_LEN : SYNC_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SYM_LAST  = CNT_W'(SYMBOL_LEN - 1);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);
`ifdef FSK_MOD_SYNC_EN
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
`ifdef FSK_MOD_SYNC_EN
    ST_SYNC   = 2'd1,
`endif
    ST_SYMBOL = 2'd2
  } state_t;

  function automatic logic signed [17:0] tone_sample(input int idx, input bit use_cos);
    real ang;
    real val;
    int  r;
    ang = 2.0 * 3.14159265358979323846 * real'(idx) / 1024.0;
    val = use_cos ? real'(AMPL) * $cos(ang) : real'(AMPL) * $sin(ang);
    r = (val >= 0.0) ? $rtoi(val + 0.5) : -$rtoi(0.5 - val);
    return 18'(r);
  endfunction

  // Rounded (k+1)*2^32/100: tone k sits at (k+1) MHz for a 100 MS/s sample rate.
  function automatic logic [31:0] phase_inc(input int k);
    logic [63:0] num;
    num = (64'(k) + 64'd1) * 64'h1_0000_0000 + 64'd50;
    return 32'(num / 64'd100);
  endfunction

  logic signed [17:0] sin_lut [1024];
  logic signed [17:0] cos_lut [1024];
  logic [31:0]        pinc_lut [16];

  for (genvar gi = 0; gi < 1024; gi++) begin : g_lut
    assign sin_lut[gi] = tone_sample(gi, 1'b0);
    assign cos_lut[gi] = tone_sample(gi, 1'b1);
  end
  for (genvar gk = 0; gk < 16; gk++) begin : g_pinc
    assign pinc_lut[gk] = phase_inc(gk);
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        phase_q, phase_d;
  logic [3:0]         fifo_mem_q [FIFO_DEPTH];
  logic [3:0]         fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [3:0]         tx_symbol_q, tx_symbol_d;
  logic signed [17:0] dac_sin_q, dac_sin_d, dac_cos_q, dac_cos_d;
  logic               push, pop, fifo_empty;

  assign sym_in_ready = (count_q != FIFO_FULL);
  assign fifo_empty   = (count_q == '0);
  assign push         = sym_in_valid & sym_in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
`ifdef FSK_MOD_SYNC_EN
          state_d = ST_SYNC;
`else
          state_d = ST_SYMBOL;
          pop     = 1'b1;
`endif
          cnt_d   = '0;
          phase_d = '0;
        end
      end
`ifdef FSK_MOD_SYNC_EN
      ST_SYNC: begin
        if (cnt_q == SYNC_LAST) begin
          state_d = ST_SYMBOL;
          pop     = 1'b1;
          cnt_d   = '0;
          phase_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      ST_SYMBOL: begin
        if (cnt_q == SYM_LAST) begin
          cnt_d   = '0;
          phase_d = '0;
          if (!fifo_empty) pop = 1'b1;
          else             state_d = ST_IDLE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          phase_d = phase_q + pinc_lut[tx_symbol_q];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs follow the state/phase registers by one cycle.
  always_comb begin
    dac_sin_d = '0;
    dac_cos_d = '0;
    case (state_q)
`ifdef FSK_MOD_SYNC_EN
      ST_SYNC: dac_sin_d = 18'(SYNC_LEVEL);
`endif
      ST_SYMBOL: begin
        dac_sin_d = sin_lut[phase_q[31:22]];
        dac_cos_d = cos_lut[phase_q[31:22]];
      end
      default: ;
    endcase
  end

  always_comb begin
    fifo_mem_d  = fifo_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    tx_symbol_d = tx_symbol_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = sym_in;
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      tx_symbol_d = fifo_mem_q[rd_ptr_q];
      rd_ptr_d    = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      phase_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tx_symbol_q <= '0;
      dac_sin_q   <= '0;
      dac_cos_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      tx_symbol_q <= tx_symbol_d;
      dac_sin_q   <= dac_sin_d;
      dac_cos_q   <= dac_cos_d;
      fifo_mem_q  <= fifo_mem_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign tx_symbol   = tx_symbol_q;
  assign dac_out_sin = dac_sin_q;
  assign dac_out_cos = dac_cos_q;

endmodule

// File: tb/tb_fsk_modulator_tx.sv
// tb/tb_fsk_modulator_tx.sv - directed self-checking bench for fsk_modulator_tx
module tb_fsk_modulator_tx;
`ifdef FSK_MOD_SYNC_EN
  localparam int PRE = 16;
`else
  localparam int PRE = 0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic [3:0]         sym_in;
  logic               sym_in_valid;
  logic               sym_in_ready;
  logic signed [17:0] dac_out_sin;
  logic signed [17:0] dac_out_cos;
  logic               busy;
  logic [3:0]         tx_symbol;

  int checks = 0;
  int errors = 0;
  int t;

  fsk_modulator_tx dut (
    .clk          (clk),
    .reset        (reset),
    .sym_in       (sym_in),
    .sym_in_valid (sym_in_valid),
    .sym_in_ready (sym_in_ready),
    .dac_out_sin  (dac_out_sin),
    .dac_out_cos  (dac_out_cos),
    .busy         (busy),
    .tx_symbol    (tx_symbol)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    t++;
  endtask

  task automatic wait_to(input int target);
    while (t < target) tick();
  endtask

  task automatic check_iq(input string tag, input int exp_sin, input int exp_cos);
    check({tag, "_sin"}, dac_out_sin, exp_sin);
    check({tag, "_cos"}, dac_out_cos, exp_cos);
  endtask

  task automatic push3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    t = -1;
    sym_in = a; sym_in_valid = 1'b1; tick();
    sym_in = b; tick();
    sym_in = c; tick();
    sym_in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base, idx, full_cnt, rise_t, j;
    bit drv, rdy_prev, full_seen, rise_seen;

    reset = 1'b1; sym_in = '0; sym_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_async_sin", dac_out_sin, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ready", sym_in_ready, 1);
    check_iq("rst", 0, 0);
    check("rst_txsym", tx_symbol, 0);

    // single symbol 0
    t = -1;
    sym_in = 4'd0; sym_in_valid = 1'b1; tick();
    sym_in_valid = 1'b0;
    check("t1_idle_busy", busy, 0);
    tick();
    check("t1_busy", busy, 1);
    check_iq("t1_lead", 0, 0);
    for (int i = 0; i < PRE; i++) begin
      tick();
      check_iq("t1_sync", 1000, 0);
    end
    base = 2 + PRE;
    wait_to(base);      check_iq("t1_n0", 0, 100000);
    wait_to(base + 25); check_iq("t1_n25", 100000, 0);
    wait_to(base + 50); check_iq("t1_n50", 0, -100000);
    wait_to(base + 75); check_iq("t1_n75", -100000, 0);
    wait_to(base + 99); check_iq("t1_n99", -6744, 99772);
    check("t1_end_busy", busy, 0);
    wait_to(base + 100); check_iq("t1_idle", 0, 0);

    // back-to-back 3, 7, 15
    repeat (5) tick();
    push3(4'd3, 4'd7, 4'd15);
    wait_to(base);       check_iq("t2_s3_n0", 0, 100000); check("t2_tx3", tx_symbol, 3);
    wait_to(base + 25);  check_iq("t2_s3_n25", 0, 100000);
    wait_to(base + 99);  check("t2_s3_n99_sin", dac_out_sin, -24893); check("t2_mid_busy", busy, 1);
    wait_to(base + 100); check_iq("t2_s7_n0", 0, 100000); check("t2_tx7", tx_symbol, 7);
    wait_to(base + 200); check_iq("t2_s15_n0", 0, 100000); check("t2_tx15", tx_symbol, 15);
    wait_to(base + 225); check_iq("t2_s15_n25", -614, 99998);
    wait_to(base + 299); check("t2_end_busy", busy, 0);
    wait_to(base + 300); check_iq("t2_idle", 0, 0);

    // six symbols 1..6 with valid held against a 4-entry FIFO
    repeat (5) tick();
    t = -1; idx = 0; full_cnt = -1; rise_t = -1; full_seen = 0; rise_seen = 0;
    rdy_prev = sym_in_ready;
    sym_in = 4'd1; sym_in_valid = 1'b1; drv = 1;
    while (t < base + 600) begin
      tick();
      if (drv && rdy_prev) idx++;
      if (!sym_in_ready && !full_seen) begin
        full_seen = 1; full_cnt = idx;
      end else if (sym_in_ready && full_seen && !rise_seen) begin
        rise_seen = 1; rise_t = t;
      end
      if (t >= base && (t - base) % 100 == 0 && (t - base) / 100 < 6) begin
        j = (t - base) / 100;
        check("t3_txsym", tx_symbol, j + 1);
        check_iq("t3_n0", 0, 100000);
      end
      if (t == base + 25)  check_iq("t3_s1_n25", 0, -100000);
      if (t == base + 425) check_iq("t3_s5_n25", 0, -100000);
      if (idx < 6) begin
        sym_in = 4'(idx + 1); sym_in_valid = 1'b1; drv = 1;
      end else begin
        sym_in_valid = 1'b0; drv = 0;
      end
      rdy_prev = sym_in_ready;
    end
    check("t3_accept_at_full", full_cnt, (PRE > 0) ? 4 : 5);
    check("t3_ready_rise_t", rise_t, (PRE > 0) ? 1 + PRE : 101 + PRE);
    check("t3_all_accepted", idx, 6);
    check("t3_end_busy", busy, 0);

    // reset at sample 50 of the second symbol
    repeat (5) tick();
    push3(4'd3, 4'd7, 4'd15);
    wait_to(base + 150);
    check("t4_pre_tx", tx_symbol, 7);
    reset = 1'b1;
    #1;
    check_iq("t4_rst", 0, 0);
    check("t4_rst_busy", busy, 0);
    check("t4_rst_ready", sym_in_ready, 1);
    check("t4_rst_tx", tx_symbol, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) tick();
    check("t4_flushed_busy", busy, 0);
    check_iq("t4_flushed", 0, 0);
    t = -1;
    sym_in = 4'd5; sym_in_valid = 1'b1; tick();
    sym_in_valid = 1'b0;
    tick();
    check("t4_busy", busy, 1);
    for (int i = 0; i < PRE; i++) begin
      tick();
      check_iq("t4_sync", 1000, 0);
    end
    wait_to(base);       check_iq("t4_s5_n0", 0, 100000); check("t4_tx5", tx_symbol, 5);
    wait_to(base + 25);  check_iq("t4_s5_n25", 0, -100000);
    wait_to(base + 100); check_iq("t4_idle", 0, 0); check("t4_end_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
